// File: rtl/memoria_param_ctrl.sv
// memoria_param_ctrl: parametrised single-port memory with post-reset clear sweep,
// request/ready handshake, pipelined reads and out-of-range address flagging.
module memoria_param_ctrl #(
    parameter int ANCHO_DATO = 12,
    parameter int ANCHO_DIR = 9,
    parameter int PROFUNDIDAD = 512,
    parameter int LATENCIA_LECTURA = 1,
    parameter logic [ANCHO_DATO-1:0] VALOR_INICIAL = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  solicitud,
    input  logic                  leer_escribir,
    input  logic [ANCHO_DIR-1:0]  direccion,
    input  logic [ANCHO_DATO-1:0] dato_escribir,
    output logic                  listo,
    output logic [ANCHO_DATO-1:0] dato_leer,
    output logic                  dato_valido,
    output logic                  error_direccion,
    output logic                  limpiando
);
    localparam int AW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
    typedef enum logic {LIMPIAR, ESPERA} estado_t;
    estado_t estado_q, estado_d;
    logic [ANCHO_DIR-1:0] contador_q, contador_d;
    logic [ANCHO_DATO-1:0] mem [PROFUNDIDAD];
    logic acepta, en_rango, we;
    logic [AW-1:0] dir_we;
    logic [ANCHO_DATO-1:0] dato_we;
    logic s1_lee_q, s1_err_q;
    logic [AW-1:0] s1_dir_q;
    logic fin_lee, fin_err;
    logic [ANCHO_DATO-1:0] fin_dato;
    logic [ANCHO_DATO-1:0] dato_leer_q;
    logic dato_valido_q, error_q;
    assign listo = estado_q == ESPERA;
    assign limpiando = estado_q == LIMPIAR;
    assign acepta = solicitud & listo;
    assign en_rango = {1'b0, direccion} < (ANCHO_DIR+1)'(PROFUNDIDAD);
    always_comb begin
        contador_d = limpiando ? contador_q + ANCHO_DIR'(1) : contador_q;
        estado_d = (limpiando && contador_q == ANCHO_DIR'(PROFUNDIDAD - 1)) ? ESPERA : estado_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= LIMPIAR;
            contador_q <= '0;
        end else begin
            estado_q <= estado_d;
            contador_q <= contador_d;
        end
    end
    // The sweep and accepted in-range writes share the single write port.
    assign we = limpiando | (acepta & ~leer_escribir & en_rango);
    assign dir_we = limpiando ? contador_q[AW-1:0] : direccion[AW-1:0];
    assign dato_we = limpiando ? VALOR_INICIAL : dato_escribir;
    always_ff @(posedge clock) begin
        if (we) mem[dir_we] <= dato_we;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_lee_q <= 1'b0;
            s1_err_q <= 1'b0;
            s1_dir_q <= '0;
        end else begin
            s1_lee_q <= acepta & leer_escribir;
            s1_err_q <= acepta & ~en_rango;
            s1_dir_q <= en_rango ? direccion[AW-1:0] : '0;
        end
    end
    if (LATENCIA_LECTURA == 2) begin : g_lat2
        logic s2_lee_q, s2_err_q;
        logic [ANCHO_DATO-1:0] s2_dato_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s2_lee_q <= 1'b0;
                s2_err_q <= 1'b0;
                s2_dato_q <= '0;
            end else begin
                s2_lee_q <= s1_lee_q;
                s2_err_q <= s1_err_q;
                s2_dato_q <= s1_err_q ? '0 : mem[s1_dir_q];
            end
        end
        assign fin_lee = s2_lee_q;
        assign fin_err = s2_err_q;
        assign fin_dato = s2_dato_q;
    end else begin : g_lat1
        assign fin_lee = s1_lee_q;
        assign fin_err = s1_err_q;
        assign fin_dato = s1_err_q ? '0 : mem[s1_dir_q];
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dato_leer_q <= '0;
            dato_valido_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            dato_valido_q <= fin_lee;
            error_q <= fin_err;
            if (fin_lee) dato_leer_q <= fin_dato;
        end
    end
    assign dato_leer = dato_leer_q;
    assign dato_valido = dato_valido_q;
    assign error_direccion = error_q;
endmodule

// File: tb/tb_memoria_param_ctrl.sv
// tb_memoria_param_ctrl: scoreboard bench driving a default instance (u0) and a
// 32-bit, 300-word, latency-2 instance (u1) with directed vectors.
module tb_memoria_param_ctrl;
    typedef struct {
        int due;
        logic v;
        logic e;
        logic [31:0] d;
    } exp_t;
    logic clock = 1'b0;
    logic reset;
    logic sol [2];
    logic rw [2];
    logic [8:0] dir [2];
    logic [31:0] wd [2];
    logic listo [2];
    logic dv [2];
    logic err [2];
    logic limp [2];
    logic [31:0] dl [2];
    logic [11:0] dl_a;
    logic [31:0] dl_b;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    assign dl[0] = 32'(dl_a);
    assign dl[1] = dl_b;
    memoria_param_ctrl #(
        .ANCHO_DATO(12), .ANCHO_DIR(9), .PROFUNDIDAD(512),
        .LATENCIA_LECTURA(1), .VALOR_INICIAL(12'h000)
    ) u0 (
        .clock(clock), .reset(reset), .solicitud(sol[0]), .leer_escribir(rw[0]),
        .direccion(dir[0]), .dato_escribir(wd[0][11:0]), .listo(listo[0]),
        .dato_leer(dl_a), .dato_valido(dv[0]), .error_direccion(err[0]), .limpiando(limp[0])
    );
    memoria_param_ctrl #(
        .ANCHO_DATO(32), .ANCHO_DIR(9), .PROFUNDIDAD(300),
        .LATENCIA_LECTURA(2), .VALOR_INICIAL(32'hDEADBEEF)
    ) u1 (
        .clock(clock), .reset(reset), .solicitud(sol[1]), .leer_escribir(rw[1]),
        .direccion(dir[1]), .dato_escribir(wd[1]), .listo(listo[1]),
        .dato_leer(dl_b), .dato_valido(dv[1]), .error_direccion(err[1]), .limpiando(limp[1])
    );
    function automatic int lat(int u);
        return u == 1 ? 2 : 1;
    endfunction
    function automatic int prof(int u);
        return u == 1 ? 300 : 512;
    endfunction
    function automatic logic [31:0] vinit(int u);
        return u == 1 ? 32'hDEADBEEF : 32'h0;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask
    task automatic push(int u, exp_t x);
        if (u == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask
    task automatic mon(int u);
        exp_t x;
        if (dv[u] || err[u]) begin
            if ((u == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output u%0d cyc=%0d dv=%b err=%b required=none", u, cyc, dv[u], err[u]);
            end else begin
                x = (u == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("due_cycle_u%0d", u), cyc, x.due);
                chk($sformatf("dato_valido_u%0d_cyc%0d", u, cyc), 32'(dv[u]), 32'(x.v));
                chk($sformatf("error_direccion_u%0d_cyc%0d", u, cyc), 32'(err[u]), 32'(x.e));
                if (x.v) chk($sformatf("dato_leer_u%0d_cyc%0d", u, cyc), dl[u], x.d);
            end
        end
    endtask
    always @(negedge clock) begin
        mon(0);
        mon(1);
    end
    task automatic issue(int u, logic r, int a, logic [31:0] d);
        exp_t x;
        sol[u] = 1'b1;
        rw[u] = r;
        dir[u] = 9'(a);
        wd[u] = d;
        x.due = cyc + 1 + lat(u);
        x.v = r;
        x.e = a >= prof(u);
        x.d = d;
        if (x.v || x.e) push(u, x);
        @(posedge clock);
        #1;
    endtask
    task automatic reset_check(string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_listo_u%0d", tag, u), 32'(listo[u]), 32'd0);
            chk($sformatf("%s_limpiando_u%0d", tag, u), 32'(limp[u]), 32'd1);
            chk($sformatf("%s_dato_valido_u%0d", tag, u), 32'(dv[u]), 32'd0);
            chk($sformatf("%s_error_u%0d", tag, u), 32'(err[u]), 32'd0);
            chk($sformatf("%s_dato_leer_u%0d", tag, u), dl[u], 32'd0);
        end
    endtask
    // Request is held high through the sweep; it must be accepted only after listo rises.
    task automatic wait_ready(int u, int exp_n);
        int n;
        exp_t x;
        n = 0;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end while (!listo[u] && n < 2000);
        chk($sformatf("clear_edges_u%0d", u), n, exp_n);
        chk($sformatf("limpiando_done_u%0d", u), 32'(limp[u]), 32'd0);
        x.due = cyc + 1 + lat(u);
        x.v = 1'b1;
        x.e = 1'b0;
        x.d = vinit(u);
        push(u, x);
        @(posedge clock);
        #1;
        sol[u] = 1'b0;
    endtask
    task automatic seq_a();
        issue(0, 1, 0, 32'h0);
        issue(0, 1, 52, 32'h0);
        issue(0, 1, 511, 32'h0);
        issue(0, 0, 5, 32'hAAA);
        issue(0, 1, 5, 32'hAAA);
        issue(0, 0, 52, 32'h005);
        issue(0, 1, 52, 32'h005);
        issue(0, 0, 1, 32'h111);
        issue(0, 0, 2, 32'h222);
        issue(0, 0, 3, 32'h333);
        issue(0, 1, 1, 32'h111);
        issue(0, 1, 2, 32'h222);
        issue(0, 1, 3, 32'h333);
        issue(0, 1, 0, 32'h0);
        sol[0] = 1'b0;
    endtask
    task automatic seq_b();
        issue(1, 1, 7, 32'hDEADBEEF);
        issue(1, 0, 1, 32'h111);
        issue(1, 0, 2, 32'h222);
        issue(1, 0, 3, 32'h333);
        issue(1, 1, 1, 32'h111);
        issue(1, 1, 2, 32'h222);
        issue(1, 1, 3, 32'h333);
        issue(1, 0, 400, 32'hFFF);
        issue(1, 1, 400, 32'h0);
        issue(1, 1, 100, 32'hDEADBEEF);
        issue(1, 1, 299, 32'hDEADBEEF);
        issue(1, 1, 300, 32'h0);
        issue(1, 0, 299, 32'h12345678);
        issue(1, 1, 299, 32'h12345678);
        sol[1] = 1'b0;
    endtask
    initial begin
        int t;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            sol[u] = 1'b0;
            rw[u] = 1'b0;
            dir[u] = '0;
            wd[u] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        reset_check("por");
        for (int u = 0; u < 2; u++) begin
            sol[u] = 1'b1;
            rw[u] = 1'b1;
            dir[u] = 9'd3;
        end
        reset = 1'b0;
        repeat (100) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        reset_check("mid");
        @(posedge clock);
        #1;
        reset = 1'b0;
        fork
            wait_ready(0, 512);
            wait_ready(1, 300);
        join
        fork
            seq_a();
            seq_b();
        join
        t = 0;
        while ((q0.size() + q1.size()) != 0 && t < 50) begin
            @(posedge clock);
            t++;
        end
        @(negedge clock);
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
        @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            sol[u] = 1'b1;
            rw[u] = 1'b1;
            dir[u] = 9'd1;
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        sol[0] = 1'b0;
        sol[1] = 1'b0;
        #1;
        reset_check("inflight");
        repeat (5) @(posedge clock);
        #1;
        reset_check("inflight_end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end
endmodule
